// File: rtl/sort_sequencer_if.sv
// sort_sequencer_if: start, random-source, sorter and display signals of the sort sequencer.
// SORT_ORDER_CHECK_EN adds the order_err status line.
interface sort_sequencer_if;
    logic       start;
    logic       rnd_valid;
    logic [3:0] rnd_data;
    logic       rnd_ready;
    logic       sorter_rst;
    logic       load_num;
    logic [3:0] random_num;
    logic       sort_trigger;
    logic       sorting_done;
    logic [3:0] sorted_0;
    logic [3:0] sorted_1;
    logic [3:0] sorted_2;
    logic [3:0] sorted_3;
    logic       busy;
    logic       done;
    logic       err;
    logic       disp_valid;
    logic [1:0] disp_idx;
    logic [3:0] disp_digit;
`ifdef SORT_ORDER_CHECK_EN
    logic       order_err;
    modport master (
        input  start, rnd_valid, rnd_data, sorting_done, sorted_0, sorted_1, sorted_2, sorted_3,
        output rnd_ready, sorter_rst, load_num, random_num, sort_trigger,
        output busy, done, err, disp_valid, disp_idx, disp_digit, order_err
    );
    modport slave (
        output start, rnd_valid, rnd_data, sorting_done, sorted_0, sorted_1, sorted_2, sorted_3,
        input  rnd_ready, sorter_rst, load_num, random_num, sort_trigger,
        input  busy, done, err, disp_valid, disp_idx, disp_digit, order_err
    );
`else
    modport master (
        input  start, rnd_valid, rnd_data, sorting_done, sorted_0, sorted_1, sorted_2, sorted_3,
        output rnd_ready, sorter_rst, load_num, random_num, sort_trigger,
        output busy, done, err, disp_valid, disp_idx, disp_digit
    );
    modport slave (
        output start, rnd_valid, rnd_data, sorting_done, sorted_0, sorted_1, sorted_2, sorted_3,
        input  rnd_ready, sorter_rst, load_num, random_num, sort_trigger,
        input  busy, done, err, disp_valid, disp_idx, disp_digit
    );
`endif
endinterface

// File: rtl/sort_sequencer.sv
// sort_sequencer: run controller for the 4-digit sort datapath (load, sort with timeout, step results out).
// Define SORT_ORDER_CHECK_EN to add the order_err output flagging an unsorted capture.
module sort_sequencer #(
    parameter int HOLD_CYCLES    = 100000000,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    sort_sequencer_if.master bus
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {IDLE, CLEAR, LOAD, LOADP, TRIG, WAIT_DONE, SHOW, FINISH, ERROR} state_t;

    state_t        state;
    logic [1:0]    load_cnt;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [3:0]    result [4];
    logic          enter_clear;

    always_comb enter_clear = bus.start && (state == IDLE || state == FINISH || state == ERROR);

`ifdef SORT_ORDER_CHECK_EN
    logic order_bad;
    always_comb order_bad = (bus.sorted_0 > bus.sorted_1) || (bus.sorted_1 > bus.sorted_2) ||
                            (bus.sorted_2 > bus.sorted_3);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            bus.sorter_rst   <= 1'b1;
            bus.rnd_ready    <= 1'b0;
            bus.load_num     <= 1'b0;
            bus.random_num   <= '0;
            bus.sort_trigger <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.disp_valid   <= 1'b0;
            bus.disp_idx     <= '0;
            bus.disp_digit   <= '0;
            load_cnt         <= '0;
            hold_cnt         <= '0;
            tmo_cnt          <= '0;
            for (int i = 0; i < 4; i++) result[i] <= '0;
`ifdef SORT_ORDER_CHECK_EN
            bus.order_err    <= 1'b0;
`endif
        end else begin
            bus.load_num <= 1'b0;
            case (state)
                IDLE: bus.sorter_rst <= 1'b0;
                CLEAR: begin
                    state          <= LOAD;
                    bus.sorter_rst <= 1'b0;
                    bus.rnd_ready  <= 1'b1;
                end
                LOAD: if (bus.rnd_valid && bus.rnd_ready) begin
                    state          <= LOADP;
                    bus.rnd_ready  <= 1'b0;
                    bus.load_num   <= 1'b1;
                    bus.random_num <= bus.rnd_data;
                end
                LOADP: begin
                    load_cnt <= load_cnt + 2'd1;
                    if (load_cnt == 2'd3) begin
                        state            <= TRIG;
                        bus.sort_trigger <= 1'b1;
                        tmo_cnt          <= '0;
                    end else begin
                        state         <= LOAD;
                        bus.rnd_ready <= 1'b1;
                    end
                end
                TRIG: state <= WAIT_DONE;
                WAIT_DONE: begin
                    // a completion arriving on the last timeout cycle still counts as success
                    if (bus.sorting_done) begin
                        state            <= SHOW;
                        bus.sort_trigger <= 1'b0;
                        result[0]        <= bus.sorted_0;
                        result[1]        <= bus.sorted_1;
                        result[2]        <= bus.sorted_2;
                        result[3]        <= bus.sorted_3;
                        bus.disp_idx     <= '0;
                        bus.disp_digit   <= bus.sorted_0;
                        bus.disp_valid   <= 1'b1;
                        hold_cnt         <= '0;
`ifdef SORT_ORDER_CHECK_EN
                        bus.order_err    <= order_bad;
`endif
                    end else if (tmo_cnt == TMO_LAST) begin
                        state            <= ERROR;
                        bus.sort_trigger <= 1'b0;
                        bus.err          <= 1'b1;
                        bus.busy         <= 1'b0;
                        bus.disp_valid   <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                SHOW: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (bus.disp_idx == 2'd3) begin
                            state    <= FINISH;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                        end else begin
                            bus.disp_idx   <= bus.disp_idx + 2'd1;
                            bus.disp_digit <= result[bus.disp_idx + 2'd1];
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                FINISH: state <= FINISH;
                ERROR: state <= ERROR;
                default: state <= IDLE;
            endcase
            // a new run may only begin from IDLE, FINISH or ERROR; this overrides the case above
            if (enter_clear) begin
                state          <= CLEAR;
                bus.sorter_rst <= 1'b1;
                bus.busy       <= 1'b1;
                bus.done       <= 1'b0;
                bus.err        <= 1'b0;
                bus.disp_valid <= 1'b0;
                load_cnt       <= '0;
`ifdef SORT_ORDER_CHECK_EN
                bus.order_err  <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_sort_sequencer.sv
// tb_sort_sequencer: randomized scoreboard bench for sort_sequencer with a behavioural
// random source and sorter; order_err is checked when SORT_ORDER_CHECK_EN is defined.
module tb_sort_sequencer;
    localparam int HOLD = 3;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sort_sequencer_if bus();
    sort_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // random source: holds rnd_valid until accepted, then idles for gap cycles
    int src_q[$];
    int exp_load_q[$];
    int gap = 0;
    int gap_cnt = 0;
    bit src_en = 0;
    bit taken = 0;
    bit hs_pending = 0;

    initial begin : src_drv
        bus.rnd_valid = 1'b0;
        bus.rnd_data  = '0;
        forever begin
            @(negedge clk);
            if (taken) begin
                taken = 0;
                bus.rnd_valid = 1'b0;
                gap_cnt = gap;
            end
            if (src_en && !bus.rnd_valid) begin
                if (gap_cnt > 0) gap_cnt--;
                else begin
                    bus.rnd_valid = 1'b1;
                    bus.rnd_data  = src_q.size() > 0 ? 4'(src_q.pop_front()) : 4'($urandom_range(0, 15));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst && bus.rnd_valid === 1'b1 && bus.rnd_ready === 1'b1) begin
            exp_load_q.push_back(int'(bus.rnd_data));
            taken = 1;
            hs_pending = 1;
        end
    end

    // sorter model: sorts what it was loaded (mod 10) unless an override result is forced
    int sorter_in[$];
    int disp_q[$];
    int done_delay = 3;
    bit tmo_mode = 0;
    bit use_ovr = 0;
    int ovr[4];
    int exp_trig = 0;
    int last_digit = 0;
`ifdef SORT_ORDER_CHECK_EN
    bit exp_oerr = 0;
`endif

    initial begin : sorter
        int r[4];
        int t;
        bus.sorting_done = 1'b0;
        bus.sorted_0 = '0;
        bus.sorted_1 = '0;
        bus.sorted_2 = '0;
        bus.sorted_3 = '0;
        forever begin
            @(negedge clk);
            if (bus.sort_trigger === 1'b1 && !tmo_mode) begin
                chk("sorter_input_count", 32'(sorter_in.size()), 32'd4);
                for (int i = 0; i < 4; i++) r[i] = i < sorter_in.size() ? sorter_in[i] : 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3 - i; j++)
                        if (r[j] > r[j+1]) begin t = r[j]; r[j] = r[j+1]; r[j+1] = t; end
                if (use_ovr) for (int i = 0; i < 4; i++) r[i] = ovr[i];
                repeat (done_delay) begin
                    @(negedge clk);
                    chk("trigger_held", 32'(bus.sort_trigger), 32'd1);
                end
                bus.sorted_0 = 4'(r[0]);
                bus.sorted_1 = 4'(r[1]);
                bus.sorted_2 = 4'(r[2]);
                bus.sorted_3 = 4'(r[3]);
                bus.sorting_done = 1'b1;
                for (int k = 0; k < 4; k++) repeat (HOLD) disp_q.push_back(k * 16 + r[k]);
                last_digit = r[3];
                exp_trig = done_delay + 1;
`ifdef SORT_ORDER_CHECK_EN
                exp_oerr = r[0] > r[1] || r[1] > r[2] || r[2] > r[3];
`endif
                @(negedge clk);
                chk("trigger_dropped", 32'(bus.sort_trigger), 32'd0);
                bus.sorting_done = 1'b0;
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents a load or a display digit
    int loads = 0;
    int trig_len = 0;
    int last_trig_len = 0;
    bit prev_done = 0;
    bit prev_err = 0;

    always @(negedge clk) begin
        if (bus.load_num === 1'b1 || hs_pending) begin
            chk("load_after_handshake", 32'(bus.load_num), 32'(hs_pending));
            if (bus.load_num === 1'b1) begin
                loads++;
                chk("ready_low_in_loadp", 32'(bus.rnd_ready), 32'd0);
                if (exp_load_q.size() == 0) chk("random_num_unexpected", 32'(bus.random_num), 32'hFFFF);
                else chk("random_num", 32'(bus.random_num), 32'(exp_load_q.pop_front()));
                sorter_in.push_back(int'(bus.random_num) % 10);
            end
        end
        hs_pending = 0;
        if (bus.sorter_rst === 1'b1) begin
            sorter_in.delete();
            loads = 0;
        end
        if (bus.sort_trigger === 1'b1) trig_len++;
        else if (trig_len != 0) begin
            last_trig_len = trig_len;
            trig_len = 0;
        end
        if (bus.disp_valid === 1'b1 && bus.busy === 1'b1) begin
            if (disp_q.size() == 0) chk("disp_unexpected", 32'({bus.disp_idx, bus.disp_digit}), 32'hFFFF);
            else chk("disp_idx_digit", 32'({bus.disp_idx, bus.disp_digit}), 32'(disp_q.pop_front()));
        end
        if (bus.done === 1'b1 && !prev_done) begin
            chk("disp_drained", 32'(disp_q.size()), 32'd0);
            chk("loads_per_run", 32'(loads), 32'd4);
            chk("trigger_len", 32'(last_trig_len), 32'(exp_trig));
            chk("finish_flags", 32'({bus.busy, bus.err, bus.disp_valid, bus.disp_idx, bus.sort_trigger}), 32'b0_0_1_11_0);
            chk("finish_digit", 32'(bus.disp_digit), 32'(last_digit));
`ifdef SORT_ORDER_CHECK_EN
            chk("order_err", 32'(bus.order_err), 32'(exp_oerr));
`endif
        end
        if (bus.err === 1'b1 && !prev_err) begin
            chk("timeout_trigger_len", 32'(last_trig_len), 32'(TMO + 1));
            chk("loads_before_timeout", 32'(loads), 32'd4);
            chk("error_flags", 32'({bus.busy, bus.sort_trigger, bus.disp_valid, bus.done}), 32'd0);
        end
        prev_done = bus.done === 1'b1;
        prev_err  = bus.err === 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run(input bit hold_start, input bit expect_err);
        bit ended = 0;
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        chk("clear_state", 32'({bus.sorter_rst, bus.busy, bus.done, bus.err, bus.disp_valid}), 32'b11000);
        @(negedge clk);
        chk("clear_pulse_over", 32'({bus.sorter_rst, bus.rnd_ready}), 32'b01);
        for (int i = 0; i < 2000 && !ended; i++) begin
            if (bus.done === 1'b1 || bus.err === 1'b1) ended = 1;
            else @(negedge clk);
        end
        bus.start = 1'b0;
        if (expect_err) chk("run_end_err", 32'({bus.err, bus.done}), 32'b10);
        else chk("run_end_done", 32'({bus.done, bus.err}), 32'b10);
        tick(2);
    endtask

    initial begin : stim
        bus.start = 1'b0;
        tick(3);
        chk("reset_outputs", 32'({bus.sorter_rst, bus.load_num, bus.sort_trigger, bus.busy, bus.done, bus.err,
                                  bus.disp_valid, bus.rnd_ready, bus.disp_idx, bus.disp_digit, bus.random_num}),
            32'({1'b1, 17'd0}));
        rst = 1'b1;
        tick(2);
        chk("idle_outputs", 32'({bus.sorter_rst, bus.busy, bus.rnd_ready}), 32'd0);
        src_en = 1;

        src_q = '{7, 2, 9, 4};
        gap = 0;
        done_delay = 3;
        run(1, 0);

        gap = 5;
        run(0, 0);

        gap = 1;
        done_delay = TMO;
        run(0, 0);
        done_delay = 1;
        run(0, 0);

        tmo_mode = 1;
        run(0, 1);
        tmo_mode = 0;
        done_delay = 2;
        run(0, 0);

        tmo_mode = 1;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        for (int i = 0; i < 200 && bus.sort_trigger !== 1'b1; i++) tick(1);
        chk("reached_wait_done", 32'(bus.sort_trigger), 32'd1);
        tick(4);
        rst = 1'b0;
        tick(1);
        chk("reset_mid_run", 32'({bus.sorter_rst, bus.sort_trigger, bus.busy, bus.done, bus.err, bus.disp_valid,
                                  bus.load_num, bus.rnd_ready}), 32'b1000_0000);
        rst = 1'b1;
        tick(3);
        chk("idle_after_reset", 32'({bus.sorter_rst, bus.busy, bus.sort_trigger, bus.err}), 32'd0);
        tmo_mode = 0;

        for (int n = 0; n < 4; n++) begin
            gap = $urandom_range(0, 3);
            done_delay = $urandom_range(1, TMO);
            run(n[0], 0);
        end

        use_ovr = 1;
        ovr = '{5, 3, 7, 9};
        run(0, 0);
        ovr = '{1, 1, 2, 8};
        run(0, 0);
        use_ovr = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
